// File: rtl/sample_feeder.sv
// Replays a small bank of stored training samples to a neuron array, holding each one
// for HOLD cycles and looping over the active set for a fixed or unbounded number of epochs.
module sample_feeder #(
    parameter int LANES  = 32,
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int HOLD   = 2,
    parameter int EPOCHS = 0,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [AW-1:0]          load_addr,
    input  logic [LANES*WIDTH-1:0] load_data,
    input  logic [63:0]            load_target,
    input  logic [AW:0]            num_samples,
    input  logic [LANES-1:0]       enable_mask,
    input  logic                   start,
    input  logic                   stop,
    output logic [LANES*WIDTH-1:0] neuron_in,
    output logic [LANES-1:0]       enabled,
    output logic [63:0]            target,
    output logic                   sample_valid,
    output logic [AW-1:0]          sample_idx,
    output logic [15:0]            epoch_count,
    output logic                   busy,
    output logic                   done
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [15:0]   EPOCHS_C  = 16'(EPOCHS);

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_DONE} state_t;

    state_t                 state_q;
    logic [LANES*WIDTH-1:0] mem_data_q [DEPTH];
    logic [63:0]            mem_tgt_q  [DEPTH];

    logic [AW-1:0]          idx_q, idx_d;
    logic [HW-1:0]          hcnt_q;
    logic [AW:0]            nsamp_q;
    logic [LANES-1:0]       mask_q;
    logic [15:0]            epoch_q, epoch_d;
    logic [LANES*WIDTH-1:0] neuron_q;
    logic [LANES-1:0]       enabled_q;
    logic [63:0]            target_q;
    logic                   valid_q, busy_q, done_q, ready_q;

    logic start_ok, last_hold, last_sample, finish;

    assign start_ok    = (num_samples != '0) && (num_samples <= DEPTH_C);
    assign last_hold   = (hcnt_q == HOLD_LAST);
    assign last_sample = ({1'b0, idx_q} == nsamp_q - (AW + 1)'(1));
    assign idx_d       = last_sample ? '0 : idx_q + AW'(1);
    assign epoch_d     = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;
    assign finish      = (EPOCHS_C != 16'd0) && (epoch_d == EPOCHS_C);

    // Sample storage is deliberately outside reset so a reset does not lose the training set.
    always_ff @(posedge clk) begin
        if (!rst && load_valid && ready_q) begin
            mem_data_q[load_addr] <= load_data;
            mem_tgt_q[load_addr]  <= load_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            hcnt_q    <= '0;
            nsamp_q   <= '0;
            mask_q    <= '0;
            epoch_q   <= '0;
            neuron_q  <= '0;
            enabled_q <= '0;
            target_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && start_ok) begin
                        state_q   <= S_PRESENT;
                        nsamp_q   <= num_samples;
                        mask_q    <= enable_mask;
                        epoch_q   <= '0;
                        idx_q     <= '0;
                        hcnt_q    <= '0;
                        neuron_q  <= mem_data_q[0];
                        target_q  <= mem_tgt_q[0];
                        enabled_q <= enable_mask;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                end
                S_PRESENT: begin
                    if (stop) begin
                        state_q   <= S_IDLE;
                        idx_q     <= '0;
                        hcnt_q    <= '0;
                        neuron_q  <= '0;
                        target_q  <= '0;
                        enabled_q <= '0;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                    end else if (!last_hold) begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end else begin
                        hcnt_q <= '0;
                        if (last_sample)
                            epoch_q <= epoch_d;
                        // Reaching the epoch limit ends the run instead of wrapping to slot 0.
                        if (last_sample && finish) begin
                            state_q   <= S_DONE;
                            idx_q     <= '0;
                            neuron_q  <= '0;
                            target_q  <= '0;
                            enabled_q <= '0;
                            valid_q   <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            idx_q    <= idx_d;
                            neuron_q <= mem_data_q[idx_d];
                            target_q <= mem_tgt_q[idx_d];
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready   = ready_q;
    assign neuron_in    = neuron_q;
    assign enabled      = enabled_q;
    assign target       = target_q;
    assign sample_valid = valid_q;
    assign sample_idx   = idx_q;
    assign epoch_count  = epoch_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Scoreboarded bench: two feeder instances (free-running HOLD=2, and EPOCHS=2/HOLD=1).
module tb_sample_feeder;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = LANES * WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          dn;
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic [63:0]   tgt;
        logic [LANES-1:0] mask;
        logic [15:0]   epoch;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // ---------------- DUT A: EPOCHS=0, HOLD=2 ----------------
    logic a_rst, a_lv, a_lr, a_start, a_stop, a_valid, a_busy, a_done;
    logic [AW-1:0] a_laddr, a_idx;
    logic [DW-1:0] a_ldata, a_neuron;
    logic [63:0] a_ltgt, a_tgt;
    logic [AW:0] a_num;
    logic [LANES-1:0] a_mask, a_en;
    logic [15:0] a_epoch;

    sample_feeder #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD(2), .EPOCHS(0)) u_a (
        .clk(clk), .rst(a_rst), .load_valid(a_lv), .load_ready(a_lr), .load_addr(a_laddr),
        .load_data(a_ldata), .load_target(a_ltgt), .num_samples(a_num), .enable_mask(a_mask),
        .start(a_start), .stop(a_stop), .neuron_in(a_neuron), .enabled(a_en), .target(a_tgt),
        .sample_valid(a_valid), .sample_idx(a_idx), .epoch_count(a_epoch), .busy(a_busy),
        .done(a_done)
    );

    // ---------------- DUT B: EPOCHS=2, HOLD=1 ----------------
    logic b_rst, b_lv, b_lr, b_start, b_stop, b_valid, b_busy, b_done;
    logic [AW-1:0] b_laddr, b_idx;
    logic [DW-1:0] b_ldata, b_neuron;
    logic [63:0] b_ltgt, b_tgt;
    logic [AW:0] b_num;
    logic [LANES-1:0] b_mask, b_en;
    logic [15:0] b_epoch;

    sample_feeder #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD(1), .EPOCHS(2)) u_b (
        .clk(clk), .rst(b_rst), .load_valid(b_lv), .load_ready(b_lr), .load_addr(b_laddr),
        .load_data(b_ldata), .load_target(b_ltgt), .num_samples(b_num), .enable_mask(b_mask),
        .start(b_start), .stop(b_stop), .neuron_in(b_neuron), .enabled(b_en), .target(b_tgt),
        .sample_valid(b_valid), .sample_idx(b_idx), .epoch_count(b_epoch), .busy(b_busy),
        .done(b_done)
    );

    logic [DW-1:0] ref_a [DEPTH];
    logic [63:0]   reft_a [DEPTH];
    logic [LANES-1:0] cur_mask_a;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int idx, input int epoch);
        exp_t e;
        e.dn    = 1'b0;
        e.idx   = AW'(idx);
        e.data  = ref_a[idx];
        e.tgt   = reft_a[idx];
        e.mask  = cur_mask_a;
        e.epoch = 16'(epoch);
        qa.push_back(e);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_valid"}, a_valid, 1'b0);
        check({tag, "_busy"}, a_busy, 1'b0);
        check({tag, "_done"}, a_done, 1'b0);
        check({tag, "_ready"}, a_lr, 1'b1);
        check({tag, "_neuron"}, a_neuron, '0);
        check({tag, "_target"}, a_tgt, '0);
        check({tag, "_enabled"}, a_en, '0);
    endtask

    task automatic cmp_rec(input string tag, input exp_t e, input logic v, input logic d,
                           input logic [AW-1:0] idx, input logic [DW-1:0] n,
                           input logic [63:0] t, input logic [LANES-1:0] en, input logic [15:0] ep);
        check({tag, "_valid"}, v, !e.dn);
        check({tag, "_done"}, d, e.dn);
        check({tag, "_idx"}, idx, e.idx);
        check({tag, "_neuron"}, n, e.data);
        check({tag, "_target"}, t, e.tgt);
        check({tag, "_enabled"}, en, e.mask);
        check({tag, "_epoch"}, ep, e.epoch);
    endtask

    // Monitors: pop one expected record per presented output cycle.
    always @(negedge clk) begin
        if (a_valid === 1'b1 || a_done === 1'b1) begin
            if (qa.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected: valid=%b done=%b idx=%0d, no record expected", a_valid, a_done, a_idx);
            end else begin
                cmp_rec("a", qa.pop_front(), a_valid, a_done, a_idx, a_neuron, a_tgt, a_en, a_epoch);
            end
        end
    end

    always @(negedge clk) begin
        if (b_valid === 1'b1 || b_done === 1'b1) begin
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected: valid=%b done=%b idx=%0d, no record expected", b_valid, b_done, b_idx);
            end else begin
                cmp_rec("b", qb.pop_front(), b_valid, b_done, b_idx, b_neuron, b_tgt, b_en, b_epoch);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [7:0] b;
        a_rst = 1; a_lv = 0; a_laddr = '0; a_ldata = '0; a_ltgt = '0; a_num = '0;
        a_mask = '0; a_start = 0; a_stop = 0;
        b_rst = 1; b_lv = 0; b_laddr = '0; b_ldata = '0; b_ltgt = '0; b_num = '0;
        b_mask = '0; b_start = 0; b_stop = 0;
        cur_mask_a = '0;
        repeat (2) tick();
        a_rst = 0; b_rst = 0;

        check_idle_a("rst");
        check("rst_epoch", a_epoch, 16'd0);
        check("rst_idx", a_idx, '0);
        check("rst_b_ready", b_lr, 1'b1);

        // Load slots 0..2: lane0 = 1,2,3, targets 10,20,30
        for (int i = 0; i < 3; i++) begin
            b = 8'(i);
            ref_a[i]  = {8'hD0 + b, 8'hC0 + b, 8'hB0 + b, b + 8'd1};
            reft_a[i] = 64'((i + 1) * 10);
            a_lv = 1; a_laddr = AW'(i); a_ldata = ref_a[i]; a_ltgt = reft_a[i];
            tick();
        end
        a_lv = 0;

        // Basic sequencing with wrap, then stop while at slot 1
        cur_mask_a = 4'b1011;
        push_a(0, 0); push_a(0, 0); push_a(1, 0); push_a(1, 0); push_a(2, 0); push_a(2, 0);
        push_a(0, 1); push_a(0, 1); push_a(1, 1);
        a_num = 3; a_mask = cur_mask_a; a_start = 1;
        tick();
        a_start = 0;
        check("run_busy", a_busy, 1'b1);
        check("run_ready", a_lr, 1'b0);
        repeat (8) tick();
        a_stop = 1;
        tick();
        a_stop = 0;
        check_idle_a("stop");

        // Illegal sample counts are ignored
        a_num = 0; a_start = 1;
        tick();
        a_start = 0;
        check("n0_busy", a_busy, 1'b0);
        check("n0_ready", a_lr, 1'b1);
        a_num = 4'(DEPTH + 1); a_start = 1;
        tick();
        a_start = 0;
        check("n9_busy", a_busy, 1'b0);
        check("n9_valid", a_valid, 1'b0);

        // Writes are refused while presenting
        cur_mask_a = 4'b1111;
        push_a(0, 0); push_a(0, 0); push_a(1, 0); push_a(1, 0); push_a(0, 1);
        a_num = 2; a_mask = cur_mask_a; a_start = 1;
        tick();
        a_start = 0;
        a_lv = 1; a_laddr = '0; a_ldata = 32'hFFFF_FFFF; a_ltgt = 64'd999;
        check("busy_ready0", a_lr, 1'b0);
        tick();
        check("busy_ready1", a_lr, 1'b0);
        a_lv = 0;
        repeat (3) tick();
        a_stop = 1;
        tick();
        a_stop = 0;

        // Reset beats start/stop; memory survives it
        cur_mask_a = 4'b0110;
        push_a(0, 0); push_a(0, 0); push_a(1, 0);
        a_num = 3; a_mask = cur_mask_a; a_start = 1;
        tick();
        a_start = 0;
        repeat (2) tick();
        a_rst = 1; a_start = 1; a_stop = 1;
        tick();
        a_rst = 0; a_start = 0; a_stop = 0;
        check_idle_a("rst2");
        check("rst2_epoch", a_epoch, 16'd0);
        push_a(0, 0); push_a(0, 0); push_a(1, 0); push_a(1, 0);
        a_start = 1;
        tick();
        a_start = 0;
        repeat (3) tick();
        a_stop = 1;
        tick();
        a_stop = 0;

        // DUT B: two single-sample epochs then a done pulse
        b_lv = 1; b_laddr = '0; b_ldata = 32'h1122_3344; b_ltgt = 64'h0123_4567_89AB_CDEF;
        tick();
        b_lv = 0;
        e.dn = 0; e.idx = '0; e.data = 32'h1122_3344; e.tgt = 64'h0123_4567_89AB_CDEF;
        e.mask = 4'b0101; e.epoch = 16'd0;
        qb.push_back(e);
        e.epoch = 16'd1;
        qb.push_back(e);
        e.dn = 1; e.data = '0; e.tgt = '0; e.mask = '0; e.epoch = 16'd2;
        qb.push_back(e);
        b_num = 1; b_mask = 4'b0101; b_start = 1;
        tick();
        b_start = 0;
        repeat (3) tick();
        check("b_end_ready", b_lr, 1'b1);
        check("b_end_busy", b_busy, 1'b0);
        check("b_end_valid", b_valid, 1'b0);
        check("b_end_epoch", b_epoch, 16'd2);

        repeat (2) tick();
        check("a_queue_empty", 64'(qa.size()), 64'd0);
        check("b_queue_empty", 64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 The block SHALL have parameter LANES, default 32, meaning number of input lanes presented to learningNeuron.
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning bits per lane.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning number of stored training samples (power of two, AW = log2(DEPTH)).
REQ-004 The block SHALL have parameter HOLD, default 2, meaning clock cycles each sample is presented (HOLD >= 1).
REQ-005 The block SHALL have parameter EPOCHS, default 0, meaning epochs to run before stopping (0 = run until stop).
REQ-006 The block SHALL have port clk, input, 1, meaning sole clock; all logic on posedge clk.
REQ-007 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 The block SHALL have port load_valid, input, 1, meaning sample write request.
REQ-009 The block SHALL have port load_ready, output, 1, meaning write accepted this cycle when high with load_valid.
REQ-010 The block SHALL have port load_addr, input, AW, meaning sample slot to write.
REQ-011 The block SHALL have port load_data, input, LANES*WIDTH, meaning packed lane vector, lane i at bits [i*WIDTH +: WIDTH].
REQ-012 The block SHALL have port load_target, input, 64, meaning expected output for that sample.
REQ-013 The block SHALL have port num_samples, input, AW+1, meaning active sample count, sampled on start.
REQ-014 The block SHALL have port enable_mask, input, LANES, meaning lane enables, sampled on start.
REQ-015 The block SHALL have port start, input, 1, meaning begin sequencing.
REQ-016 The block SHALL have port stop, input, 1, meaning abort sequencing.
REQ-017 The block SHALL have port neuron_in, output, LANES*WIDTH, meaning lane vector to learningNeuron.
REQ-018 The block SHALL have port enabled, output, LANES, meaning lane enables to learningNeuron.
REQ-019 The block SHALL have port target, output, 64, meaning target for backPropperStart.
REQ-020 The block SHALL have port sample_valid, output, 1, meaning neuron_in/target are a live sample.
REQ-021 The block SHALL have port sample_idx, output, AW, meaning index of presented sample.
REQ-022 The block SHALL have port epoch_count, output, 16, meaning completed epochs.
REQ-023 The block SHALL have ports busy and done, output, 1 each, meaning running and one-cycle completion pulse.

Function
REQ-024 The block SHALL implement FSM states IDLE, PRESENT, DONE; all outputs registered.
REQ-025 The block SHALL assert load_ready exactly when state is IDLE; a write SHALL occur on an edge where load_valid and load_ready are both high.
REQ-026 The block SHALL, in IDLE on an edge with start high and 1 <= num_samples <= DEPTH, latch num_samples and enable_mask, clear epoch_count, and enter PRESENT with sample_idx 0.
REQ-027 The block SHALL ignore start when num_samples is 0 or exceeds DEPTH, or when not in IDLE.
REQ-028 The block SHALL, in PRESENT, drive neuron_in, target from slot sample_idx, enabled from latched mask, sample_valid=1, busy=1.
REQ-029 The block SHALL hold each sample exactly HOLD cycles, then advance sample_idx by 1 with no gap cycle.
REQ-030 The block SHALL, after the last active sample's HOLD cycles, wrap sample_idx to 0 and increment epoch_count (saturating at 16'hFFFF) on the same edge.
REQ-031 The block SHALL, when EPOCHS != 0 and the increment makes epoch_count equal EPOCHS, enter DONE instead of wrapping.
REQ-032 The block SHALL, in DONE, assert done for one cycle with sample_valid=0, then return to IDLE; epoch_count holds until next start.
REQ-033 The block SHALL, on stop high in PRESENT, enter IDLE at that edge with no done pulse; stop has priority over advance; stop in IDLE/DONE is ignored.
REQ-034 The block SHALL, whenever sample_valid=0, drive neuron_in, target, enabled to 0.

Reset
REQ-035 The block SHALL, on rst high at an edge, enter IDLE and zero all outputs except load_ready=1, regardless of state; stored samples are not cleared.
REQ-036 The block SHALL give rst priority over start, stop, and load_valid on the same edge.

Verification
REQ-037 Load slots 0..2 (lane0 = 1,2,3; targets 10,20,30), num_samples=3, HOLD=2, start -> sample_idx 0,0,1,1,2,2,0 with matching neuron_in/target, epoch_count 1 on the wrap edge.
REQ-038 EPOCHS=2, num_samples=1, HOLD=1 -> sample_valid for 2 cycles, done one cycle, then IDLE with epoch_count=2 and load_ready=1.
REQ-039 Stop asserted mid-sample while at sample_idx 1 -> next cycle IDLE, sample_valid=0, all data outputs 0, no done.
REQ-040 Start with num_samples=0 and num_samples=DEPTH+1 -> remains IDLE, busy=0.
REQ-041 load_valid during PRESENT -> load_ready=0, memory unchanged (verify by next run's data).
REQ-042 rst asserted in PRESENT together with start and stop -> IDLE next cycle, outputs 0, previously loaded samples still replayed on next start.
